// File: rtl/pkt_fifo_if.sv
// Packet FIFO bus: writer-side packet controls plus reader-side head word and status.
// The master drives writes, reads and error clear; the slave (the FIFO) returns data and flags.
interface pkt_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CW         = 9
);
  logic                  w_enable;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;
  logic                  w_discard;
  logic                  r_enable;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic [CW-1:0]         pkt_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_enable, w_data, w_last, w_discard, r_enable, clr_err,
    input  r_data, r_last, empty, full, almost_full, count, pkt_count, overflow, underflow
  );

  modport slave (
    input  w_enable, w_data, w_last, w_discard, r_enable, clr_err,
    output r_data, r_last, empty, full, almost_full, count, pkt_count, overflow, underflow
  );
endinterface

// File: rtl/pkt_fifo.sv
// Packet FIFO with speculative writes: words become visible to the reader only once the
// packet's last word is written; oversize or discarded packets are rewound and never seen.
module pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int AFULL_LVL  = 192,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        n_rst,
  pkt_fifo_if.slave   bus
);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  logic [DATA_WIDTH:0] mem_r [DEPTH];
  logic [PW-1:0]       rd_ptr_r, cm_ptr_r, sp_ptr_r;
  logic [CW-1:0]       count_r, pkt_count_r, unc_r;
  logic                poisoned_r, overflow_r, underflow_r;
  logic                empty_r, full_r, afull_r;

  logic [PW-1:0]       rd_ptr_s, cm_ptr_s, sp_ptr_s;
  logic [CW-1:0]       count_s, pkt_count_s, unc_s, occ_s;
  logic [CW-1:0]       commit_len_s, pop_s, pkt_pop_s, pkt_add_s;
  logic                poisoned_s, overflow_s, underflow_s;
  logic                head_last_s, rd_acc_s, wr_acc_s, commit_s, rewind_s;
  logic                ovf_evt_s, udf_evt_s;

  // Next-state for pointers, counters and flags, all decided from pre-edge registered state.
  always_comb begin
    head_last_s = mem_r[rd_ptr_r][DATA_WIDTH];
    rd_acc_s    = bus.r_enable & ~empty_r;
    udf_evt_s   = bus.r_enable & empty_r;
    ovf_evt_s   = bus.w_enable & full_r & ~bus.w_discard;
    wr_acc_s    = bus.w_enable & ~full_r & ~bus.w_discard & ~poisoned_r;
    commit_s    = wr_acc_s & bus.w_last;
    rewind_s    = bus.w_discard | (poisoned_r & bus.w_enable & bus.w_last);

    sp_ptr_s    = sp_ptr_r;
    cm_ptr_s    = cm_ptr_r;
    unc_s       = unc_r;
    poisoned_s  = poisoned_r;
    // A poisoned packet ending (or an explicit discard) wins over any new error event.
    if (rewind_s) begin
      sp_ptr_s   = cm_ptr_r;
      unc_s      = {CW{1'b0}};
      poisoned_s = 1'b0;
    end else if (commit_s) begin
      sp_ptr_s   = sp_ptr_r + PONE_C;
      cm_ptr_s   = sp_ptr_r + PONE_C;
      unc_s      = {CW{1'b0}};
    end else if (wr_acc_s) begin
      sp_ptr_s   = sp_ptr_r + PONE_C;
      unc_s      = unc_r + ONE_C;
    end else if (ovf_evt_s) begin
      poisoned_s = 1'b1;
    end else begin
      poisoned_s = poisoned_r;
    end

    rd_ptr_s     = rd_acc_s ? (rd_ptr_r + PONE_C) : rd_ptr_r;
    commit_len_s = commit_s ? (unc_r + ONE_C) : {CW{1'b0}};
    pop_s        = {{(CW-1){1'b0}}, rd_acc_s};
    pkt_pop_s    = {{(CW-1){1'b0}}, rd_acc_s & head_last_s};
    pkt_add_s    = {{(CW-1){1'b0}}, commit_s};
    count_s      = count_r + commit_len_s - pop_s;
    pkt_count_s  = pkt_count_r + pkt_add_s - pkt_pop_s;
    occ_s        = count_s + unc_s;

    overflow_s   = ovf_evt_s | (overflow_r & ~bus.clr_err);
    underflow_s  = udf_evt_s | (underflow_r & ~bus.clr_err);
  end

  // Control state and registered status flags; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      rd_ptr_r    <= {PW{1'b0}};
      cm_ptr_r    <= {PW{1'b0}};
      sp_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      pkt_count_r <= {CW{1'b0}};
      unc_r       <= {CW{1'b0}};
      poisoned_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      afull_r     <= 1'b0;
    end else begin
      rd_ptr_r    <= rd_ptr_s;
      cm_ptr_r    <= cm_ptr_s;
      sp_ptr_r    <= sp_ptr_s;
      count_r     <= count_s;
      pkt_count_r <= pkt_count_s;
      unc_r       <= unc_s;
      poisoned_r  <= poisoned_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
      empty_r     <= (count_s == {CW{1'b0}});
      full_r      <= (occ_s == DEPTH_C);
      afull_r     <= (occ_s >= AFULL_C);
    end
  end

  // Storage array; contents are left unreset since only pointer-qualified words are ever read.
  always_ff @(posedge clk) begin
    if (wr_acc_s & ~n_rst) begin
      mem_r[sp_ptr_r] <= {bus.w_last, bus.w_data};
    end
  end

  assign bus.r_data      = mem_r[rd_ptr_r][DATA_WIDTH-1:0];
  assign bus.r_last      = ~empty_r & head_last_s;
  assign bus.empty       = empty_r;
  assign bus.full        = full_r;
  assign bus.almost_full = afull_r;
  assign bus.count       = count_r;
  assign bus.pkt_count   = pkt_count_r;
  assign bus.overflow    = overflow_r;
  assign bus.underflow   = underflow_r;
endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of committed and pending packets.
module tb_pkt_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk;
  logic n_rst;
  int   n_vec = 0;
  int   n_err = 0;

  pkt_fifo_if #(.DATA_WIDTH(DW), .CW(CW)) bus ();

  pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: committed words visible to the reader, and words of the packet still being written.
  logic [DW:0] cq[$];
  logic [DW:0] uq[$];
  bit          pois    = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_udf   = 1'b0;
  bit          started = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_pkts();
    int n = 0;
    foreach (cq[i]) if (cq[i][DW]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    bit m_full, m_empty, ovf_e, udf_e;
    if (n_rst) begin
      cq.delete(); uq.delete();
      pois = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; started = 1'b1;
    end else begin
      m_full  = (cq.size() + uq.size()) == DEPTH;
      m_empty = (cq.size() == 0);
      ovf_e   = bus.w_enable && m_full && !bus.w_discard;
      udf_e   = bus.r_enable && m_empty;
      if (bus.r_enable && !m_empty) void'(cq.pop_front());
      if (bus.w_discard) begin
        uq.delete(); pois = 1'b0;
      end else if (bus.w_enable) begin
        if (pois) begin
          if (bus.w_last) begin uq.delete(); pois = 1'b0; end
        end else if (m_full) begin
          pois = 1'b1;
        end else begin
          uq.push_back({bus.w_last, bus.w_data});
          if (bus.w_last) begin
            foreach (uq[i]) cq.push_back(uq[i]);
            uq.delete();
          end
        end
      end
      m_ovf = ovf_e || (m_ovf && !bus.clr_err);
      m_udf = udf_e || (m_udf && !bus.clr_err);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int occ;
    if (started) begin
      occ = cq.size() + uq.size();
      chk("m_empty", int'(bus.empty), int'(cq.size() == 0));
      chk("m_full", int'(bus.full), int'(occ == DEPTH));
      chk("m_afull", int'(bus.almost_full), int'(occ >= AFULL));
      chk("m_count", int'(bus.count), cq.size());
      chk("m_pkt_count", int'(bus.pkt_count), m_pkts());
      chk("m_overflow", int'(bus.overflow), int'(m_ovf));
      chk("m_underflow", int'(bus.underflow), int'(m_udf));
      if (cq.size() != 0) begin
        chk("m_r_data", int'(bus.r_data), int'(cq[0][DW-1:0]));
        chk("m_r_last", int'(bus.r_last), int'(cq[0][DW]));
      end
    end
  end

  task automatic drive(input bit we, input bit [DW-1:0] wd, input bit wl, input bit dsc,
                       input bit re, input bit clr, input bit rst);
    @(negedge clk);
    bus.w_enable = we; bus.w_data = wd; bus.w_last = wl; bus.w_discard = dsc;
    bus.r_enable = re; bus.clr_err = clr; n_rst = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.w_enable = 1'b0; bus.w_data = 8'h00; bus.w_last = 1'b0; bus.w_discard = 1'b0;
    bus.r_enable = 1'b0; bus.clr_err = 1'b0; n_rst = 1'b0;

    // Reset and a 3-word packet.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_afull", int'(bus.almost_full), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_pkt", int'(bus.pkt_count), 0);
    chk("rst_r_last", int'(bus.r_last), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_udf", int'(bus.underflow), 0);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p3_empty_w1", int'(bus.empty), 1);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p3_empty_w2", int'(bus.empty), 1);
    drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p3_empty_w3", int'(bus.empty), 0);
    chk("p3_count", int'(bus.count), 3);
    chk("p3_pkt", int'(bus.pkt_count), 1);
    chk("p3_head", int'(bus.r_data), 8'h11);
    chk("p3_head_last", int'(bus.r_last), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p3_rd1_data", int'(bus.r_data), 8'h22);
    chk("p3_rd1_last", int'(bus.r_last), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p3_rd2_data", int'(bus.r_data), 8'h33);
    chk("p3_rd2_last", int'(bus.r_last), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p3_rd3_empty", int'(bus.empty), 1);
    chk("p3_rd3_pkt", int'(bus.pkt_count), 0);

    // Discarded partial packet, then a 1-word packet.
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dsc_partial_empty", int'(bus.empty), 1);
    drive(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dsc_empty", int'(bus.empty), 1);
    chk("dsc_full", int'(bus.full), 0);
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dsc_count", int'(bus.count), 1);
    chk("dsc_pkt", int'(bus.pkt_count), 1);
    chk("dsc_data", int'(bus.r_data), 8'hA5);
    chk("dsc_last", int'(bus.r_last), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dsc_drained", int'(bus.empty), 1);

    // Underflow and clear priority.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("udf_set", int'(bus.underflow), 1);
    chk("udf_count", int'(bus.count), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("udf_clr", int'(bus.underflow), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("udf_clr_vs_evt", int'(bus.underflow), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("udf_clr2", int'(bus.underflow), 0);

    // Fill with an uncommitted oversize packet.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 5) chk("fill_afull5", int'(bus.almost_full), 0);
      if (i == 6) chk("fill_afull6", int'(bus.almost_full), 1);
      if (i == 7) chk("fill_full7", int'(bus.full), 0);
      if (i == 8) chk("fill_full8", int'(bus.full), 1);
    end
    chk("fill_count", int'(bus.count), 0);
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_full", int'(bus.full), 1);
    drive(1'b1, 8'h9A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_rewind_full", int'(bus.full), 0);
    chk("ovf_rewind_afull", int'(bus.almost_full), 0);
    chk("ovf_rewind_empty", int'(bus.empty), 1);
    chk("ovf_rewind_pkt", int'(bus.pkt_count), 0);
    chk("ovf_sticky", int'(bus.overflow), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", int'(bus.overflow), 0);

    // Streaming 1-word packets across pointer wrap.
    drive(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("strm_count", int'(bus.count), 1);
      chk("strm_data", int'(bus.r_data), 8'h40 + i);
    end
    chk("strm_ovf", int'(bus.overflow), 0);
    chk("strm_udf", int'(bus.underflow), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset with two committed packets and a partial one pending.
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_pkt", int'(bus.pkt_count), 2);
    chk("pre_rst_afull", int'(bus.almost_full), 1);
    drive(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_empty", int'(bus.empty), 1);
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_pkt", int'(bus.pkt_count), 0);
    chk("mid_rst_afull", int'(bus.almost_full), 0);

    // Random traffic in phases of light, medium and heavy reading.
    for (int ph = 0; ph < 12; ph++) begin
      int rp;
      rp = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 50 : 85);
      for (int c = 0; c < 250; c++) begin
        drive($urandom_range(0, 99) < 65, 8'($urandom_range(0, 255)),
              $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 5,
              $urandom_range(0, 199) < 1);
      end
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pkt_fifo.md
PKT_FIFO -- requirements
Module: pkt_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per stored word.
REQ-002 Parameter DEPTH, default 256, word capacity; SHALL be a power of two >= 4.
REQ-003 Parameter AFULL_LVL, default 192, total-occupancy level at which almost_full asserts; 1 <= AFULL_LVL <= DEPTH.
REQ-004 Derived CW = $clog2(DEPTH+1), width of occupancy counters.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 n_rst  in  1  reset; synchronous, active-high (1 = reset at next rising edge).
REQ-007 w_enable  in  1  write one word this cycle.
REQ-008 w_data  in  DATA_WIDTH  write word.
REQ-009 w_last  in  1  qualified by w_enable; word is last of packet, commits packet.
REQ-010 w_discard  in  1  drop all uncommitted words of current packet.
REQ-011 r_enable  in  1  pop head word.
REQ-012 clr_err  in  1  clear sticky error flags.
REQ-013 r_data  out  DATA_WIDTH  head word, first-word-fall-through; valid while !empty.
REQ-014 r_last  out  1  end-of-packet marker stored with head word.
REQ-015 empty  out  1  no committed words available.
REQ-016 full  out  1  total occupancy (committed + uncommitted) == DEPTH.
REQ-017 almost_full  out  1  total occupancy >= AFULL_LVL.
REQ-018 count  out  CW  committed words available to reader.
REQ-019 pkt_count  out  CW  complete committed packets held.
REQ-020 overflow  out  1  sticky; write attempted while full.
REQ-021 underflow  out  1  sticky; read attempted while empty.

Function
REQ-022 Storage: DEPTH x (DATA_WIDTH+1) array holding word plus last bit; read pointer, committed write pointer, speculative write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-023 Accepted write (w_enable & !full & !w_discard & !poisoned): store {w_last, w_data} at speculative pointer, advance it by 1.
REQ-024 Accepted write with w_last: committed pointer := new speculative pointer; count += packet length; pkt_count += 1; words visible to reader the cycle after the write edge.
REQ-025 w_discard: speculative pointer := committed pointer; poisoned cleared; any coincident write (incl. w_last) ignored; committed data, count, pkt_count unaffected.
REQ-026 Write with full asserted: word dropped, overflow := 1, poisoned := 1; full evaluated pre-edge, so a simultaneous read does not admit the write.
REQ-027 While poisoned, writes not stored; w_enable & w_last rewinds speculative pointer to committed pointer and clears poisoned (packet auto-discarded, never visible).
REQ-028 Read (r_enable & !empty): read pointer += 1, count -= 1; if popped word has last bit, pkt_count -= 1.
REQ-029 Read with empty: no state change except underflow := 1.
REQ-030 Same-cycle commit and read: count = count - 1 + packet length; pkt_count adjusted by both; no lost update.
REQ-031 empty = (count == 0); full and almost_full from total occupancy = count + uncommitted words; all outputs derived from registered state (no input-to-output combinational path).
REQ-032 clr_err clears overflow and underflow; a new error event in the same cycle wins (flag stays 1).
REQ-033 Packets longer than DEPTH cannot commit: overflow/poison path applies, never a wrapped partial commit.

Reset
REQ-034 n_rst = 1 at a rising edge: all pointers 0, count 0, pkt_count 0, poisoned 0, overflow 0, underflow 0; empty 1, full 0, almost_full 0, r_last 0; array contents need not reset.
REQ-035 Reset mid-packet discards committed and uncommitted data; reset overrides all other inputs that cycle.

Verification
REQ-036 Reset, then write 3 words 0x11,0x22,0x33 (last on 0x33) -> empty 1 until cycle after 0x33 write, then count 3, pkt_count 1, r_data 0x11; three reads yield 0x11,0x22,0x33 with r_last 0,0,1, empty 1.
REQ-037 Write 4 words without last, assert w_discard, then 1-word packet 0xA5 -> only 0xA5 ever read, count 1, pkt_count 1.
REQ-038 DEPTH=8, AFULL_LVL=6: write 8-word packet -> almost_full at occupancy 6, full at 8; 9th write -> overflow 1, following w_last discards packet, occupancy unchanged.
REQ-039 Read while empty -> underflow 1, pointers unchanged; clr_err -> underflow 0; clr_err with simultaneous empty read -> underflow stays 1.
REQ-040 Continuous 1-word packets written and read every cycle across >2*DEPTH words -> data in order across pointer wrap, count stable at 1, no error flags.
REQ-041 Assert n_rst with 2 committed packets and one partial -> next cycle empty 1, count 0, pkt_count 0, almost_full 0.
